fa_response_checker: RTL and testbench
======================================

Name: fa_response_checker

Overview:
- Synthesizable response checker for the full-adder datapath; the consuming end of the full-adder stimulus/DUT interface.
- Observes the operand triple {a,b,cin} and the DUT results {sum,cout}, and compares them against the golden equations on each strobe.
- Counts vectors, errors and input coverage over a run of NUM_VECTORS samples, then reports pass/fail.
- Used on-board (LEDs) and in benches as a self-check monitor in place of waveform inspection.

Parameters:
- NUM_VECTORS, 8, number of accepted samples per run; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of vec_count.
- ERR_W, 4, width of err_count; saturates at 2^ERR_W-1.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new run (pulse; level also accepted).
- sample_en  in  1  qualifies a,b,cin,sum,cout this cycle.
- a  in  1  observed operand A.
- b  in  1  observed operand B.
- cin  in  1  observed carry-in.
- sum  in  1  DUT sum output.
- cout  in  1  DUT carry output.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done: err_count==0 and coverage==8'hFF.
- err_count  out  ERR_W  saturating mismatch count.
- vec_count  out  CNT_W  samples accepted this run.
- coverage  out  8  bit k set once {a,b,cin}==k has been sampled.
- first_err_vec  out  3  {a,b,cin} of first mismatching sample.
- first_err_valid  out  1  first_err_vec holds a captured value.

Behaviour:
- Reset (rst=1 at clock edge) places the FSM in IDLE and clears every output to 0. Reset mid-run aborts the run; no partial result is retained. rst has priority over all other inputs.
- Golden model: exp_sum = a^b^cin; exp_cout = (a&b)|(a&cin)|(b&cin). A sample mismatches if sum!=exp_sum or cout!=exp_cout; a single sample counts as one error even if both bits are wrong.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN next cycle.
  - On that same edge, err_count, vec_count, coverage, first_err_vec and first_err_valid are cleared.
  - sample_en is ignored in IDLE, including in the cycle start is asserted.
- RUN (busy=1): each cycle with sample_en=1, the following update on that edge (results visible 1 cycle after the sampled edge):
  - vec_count increments by 1.
  - coverage[{a,b,cin}] is set.
  - On a mismatch, err_count increments, holding at all-ones (no wrap).
  - On a mismatch with first_err_valid=0, first_err_vec<= {a,b,cin} and first_err_valid<=1. Later errors do not overwrite.
  - start is ignored in RUN.
  - When sample_en=1 and vec_count==NUM_VECTORS-1, that sample is processed and the FSM enters DONE on the same edge.
  - Cycles with sample_en=0 change nothing.
- DONE (done=1):
  - Counters are frozen and sample_en is ignored.
  - pass = (err_count==0) && (coverage==8'hFF), held stable.
  - start=1 -> RUN with counters cleared, exactly as from IDLE.
  - done and pass drop on the edge that enters RUN.
- Outside DONE, pass=0. busy and done are never high together.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset, pulse start, then drive the ascending {a,b,cin} counter 0..7 with a correct DUT, sample_en every other cycle -> done=1 after the 8th accepted sample; vec_count=8, err_count=0, coverage=8'hFF, pass=1, first_err_valid=0.
- Same sequence with cout forced 0 -> mismatches at vectors 3,5,6,7; err_count=4, first_err_vec=3'b011, first_err_valid=1, pass=0.
- Correct DUT but vector 7 replaced by a repeat of 6 -> err_count=0, coverage=8'h7F, pass=0.
- Sum inverted on all vectors, NUM_VECTORS=20, ERR_W=4, stimulus wraps 0..7 -> err_count saturates at 15 (no wrap to 0), vec_count=20, first_err_vec=3'b000.
- rst asserted after 4 accepted samples -> next cycle all outputs 0 and FSM in IDLE; further sample_en without start leaves vec_count=0.
- In DONE, hold sample_en=1 for 5 cycles -> counters unchanged. Then start=1 together with sample_en=1 -> RUN with counters cleared and that cycle's sample not counted (vec_count=0 one cycle later).

Source files
------------

// File: rtl/fa_response_checker.sv
// fa_response_checker
//
// Self-check monitor for a full-adder datapath. It watches the operand triple
// {a,b,cin} and the results {sum,cout}, compares them against the golden adder
// equations on each qualified sample, and accumulates a vector count, a
// saturating error count, and input coverage over a run of NUM_VECTORS samples.
// At the end of the run it reports pass/fail.
//
// Ports:
//   clk             in   system clock; all state changes on the rising edge
//   rst             in   synchronous active-high reset
//   start           in   begin a new run (ignored while a run is in progress)
//   sample_en       in   qualifies a, b, cin, sum and cout this cycle
//   a, b, cin       in   observed operands
//   sum, cout       in   observed adder results
//   busy            out  run in progress
//   done            out  run finished; results frozen
//   pass            out  done with no errors and full input coverage
//   err_count       out  mismatching samples, saturating at all-ones
//   vec_count       out  samples accepted in this run
//   coverage        out  bit k set once {a,b,cin}==k has been sampled
//   first_err_vec   out  {a,b,cin} of the first mismatching sample
//   first_err_valid out  first_err_vec holds a captured value
module fa_response_checker #(
  parameter int unsigned NUM_VECTORS = 8,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_en,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [7:0]       coverage,
  output logic [2:0]       first_err_vec,
  output logic             first_err_valid
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] LastVec = CNT_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ErrMax  = '1;

  state_e           state;
  logic [2:0]       vec;
  logic             exp_sum;
  logic             exp_cout;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;
  logic [7:0]       cov_next;

  assign vec = {a, b, cin};

  // Per-sample evaluation; only committed to state while running.
  always_comb begin
    exp_sum  = a ^ b ^ cin;
    exp_cout = (a & b) | (a & cin) | (b & cin);
    mismatch = (sum != exp_sum) || (cout != exp_cout);
    err_next = err_count;
    if (mismatch && (err_count != ErrMax)) begin
      err_next = err_count + 1'b1;
    end
    cov_next = coverage | (8'd1 << vec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= StIdle;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      vec_count       <= '0;
      coverage        <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        StIdle, StDone: begin
          // Sample data in this cycle is deliberately dropped, even with start.
          if (start) begin
            state           <= StRun;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            vec_count       <= '0;
            coverage        <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
          end
        end
        StRun: begin
          if (sample_en) begin
            vec_count <= vec_count + 1'b1;
            coverage  <= cov_next;
            err_count <= err_next;
            if (mismatch && !first_err_valid) begin
              first_err_vec   <= vec;
              first_err_valid <= 1'b1;
            end
            if (vec_count == LastVec) begin
              // pass is registered from the post-update totals of the last sample.
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0) && (cov_next == 8'hFF);
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_response_checker.sv
// Bench for fa_response_checker: two instances (8-vector and 20-vector runs)
// share one stimulus stream. A sample-log model computes every output from the
// accepted samples each cycle; directed scenarios add literal expectations.
module tb_fa_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, sample_en = 1'b0;
  logic a = 1'b0, b = 1'b0, cin = 1'b0, sum = 1'b0, cout = 1'b0;

  logic       busy8, done8, pass8, fev_ok8;
  logic [3:0] err8;
  logic [7:0] vec8, cov8;
  logic [2:0] fev8;

  logic       busy20, done20, pass20, fev_ok20;
  logic [3:0] err20;
  logic [7:0] vec20, cov20;
  logic [2:0] fev20;

  fa_response_checker dut8 (
    .clk(clk), .rst(rst), .start(start), .sample_en(sample_en),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy8), .done(done8), .pass(pass8), .err_count(err8),
    .vec_count(vec8), .coverage(cov8), .first_err_vec(fev8),
    .first_err_valid(fev_ok8)
  );

  fa_response_checker #(.NUM_VECTORS(20)) dut20 (
    .clk(clk), .rst(rst), .start(start), .sample_en(sample_en),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy20), .done(done20), .pass(pass20), .err_count(err20),
    .vec_count(vec20), .coverage(cov20), .first_err_vec(fev20),
    .first_err_valid(fev_ok20)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per instance, a run phase (0 idle, 1 running, 2 done) and a log of
  // accepted samples {a,b,cin,sum,cout}. Outputs are derived from the log.
  int         lim [2] = '{8, 20};
  int         phase [2];
  int         n_s [2];
  logic [4:0] log_s [2][32];
  bit         model_ok = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Returns {sum,cout} from the arithmetic sum of the operand bits.
  function automatic logic [1:0] golden(input logic [2:0] v);
    int t;
    t = int'(v[2]) + int'(v[1]) + int'(v[0]);
    return {logic'(t % 2 == 1), logic'(t >= 2)};
  endfunction

  task automatic model_step(input int i);
    if (rst) begin
      phase[i] = 0;
      n_s[i]   = 0;
    end else if (phase[i] != 1) begin
      if (start) begin
        phase[i] = 1;
        n_s[i]   = 0;
      end
    end else if (sample_en) begin
      log_s[i][n_s[i]] = {a, b, cin, sum, cout};
      n_s[i]++;
      if (n_s[i] == lim[i]) phase[i] = 2;
    end
  endtask

  task automatic model_expect(input int i, output logic [31:0] e_busy, output logic [31:0] e_done,
                              output logic [31:0] e_pass, output logic [31:0] e_err,
                              output logic [31:0] e_vec, output logic [31:0] e_cov,
                              output logic [31:0] e_fev, output logic [31:0] e_fok);
    int errs;
    errs  = 0;
    e_cov = 0;
    e_fev = 0;
    e_fok = 0;
    for (int k = 0; k < n_s[i]; k++) begin
      logic [2:0] v;
      v = log_s[i][k][4:2];
      e_cov = e_cov | (32'd1 << v);
      if (log_s[i][k][1:0] != golden(v)) begin
        errs++;
        if (e_fok == 0) begin
          e_fok = 1;
          e_fev = 32'(v);
        end
      end
    end
    e_err  = (errs > 15) ? 15 : errs;
    e_vec  = n_s[i];
    e_busy = (phase[i] == 1) ? 1 : 0;
    e_done = (phase[i] == 2) ? 1 : 0;
    e_pass = (phase[i] == 2 && errs == 0 && e_cov == 32'hFF) ? 1 : 0;
  endtask

  task automatic compare_inst(input int i, input string tag, input logic bz, input logic dn,
                              input logic ps, input logic [3:0] er, input logic [7:0] vc,
                              input logic [7:0] cv, input logic [2:0] fv, input logic fo);
    logic [31:0] eb, ed, ep, ee, ev, ec, ef, eo;
    model_expect(i, eb, ed, ep, ee, ev, ec, ef, eo);
    check({tag, ".busy"}, 32'(bz), eb);
    check({tag, ".done"}, 32'(dn), ed);
    check({tag, ".pass"}, 32'(ps), ep);
    check({tag, ".err_count"}, 32'(er), ee);
    check({tag, ".vec_count"}, 32'(vc), ev);
    check({tag, ".coverage"}, 32'(cv), ec);
    check({tag, ".first_err_vec"}, 32'(fv), ef);
    check({tag, ".first_err_valid"}, 32'(fo), eo);
  endtask

  // Compare process: advance the model on each edge, check outputs 1 ns later.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) model_ok = 1'b1;
      model_step(0);
      model_step(1);
      if (model_ok) begin
        #1;
        compare_inst(0, "dut8", busy8, done8, pass8, err8, vec8, cov8, fev8, fev_ok8);
        compare_inst(1, "dut20", busy20, done20, pass20, err20, vec20, cov20, fev20, fev_ok20);
      end
    end
  end

  task automatic step(input logic r, input logic st, input logic se, input logic [2:0] v,
                      input logic s, input logic c);
    @(negedge clk);
    rst       = r;
    start     = st;
    sample_en = se;
    {a, b, cin} = v;
    sum       = s;
    cout      = c;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic reset_and_start();
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  // mode 0: correct, 1: cout stuck 0, 2: sum inverted, 3: vector 7 replaced by 6.
  task automatic run_vecs(input int mode, input int count);
    for (int k = 0; k < count; k++) begin
      logic [2:0] v;
      logic [1:0] g;
      v = 3'(k % 8);
      if (mode == 3 && v == 3'd7) v = 3'd6;
      g = golden(v);
      if (mode == 1) g[0] = 1'b0;
      if (mode == 2) g[1] = ~g[1];
      step(1'b0, 1'b0, 1'b1, v, g[1], g[0]);
      idle();
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    idle();
    check("reset_busy8", 32'(busy8), 0);
    check("reset_vec8", 32'(vec8), 0);

    // Clean ascending run.
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    run_vecs(0, 8);
    check("s1_done", 32'(done8), 1);
    check("s1_vec", 32'(vec8), 8);
    check("s1_err", 32'(err8), 0);
    check("s1_cov", 32'(cov8), 32'hFF);
    check("s1_pass", 32'(pass8), 1);
    check("s1_fev_valid", 32'(fev_ok8), 0);

    // cout stuck at 0.
    reset_and_start();
    run_vecs(1, 8);
    check("s2_err", 32'(err8), 4);
    check("s2_fev", 32'(fev8), 3);
    check("s2_fev_valid", 32'(fev_ok8), 1);
    check("s2_pass", 32'(pass8), 0);

    // Missing vector 7.
    reset_and_start();
    run_vecs(3, 8);
    check("s3_err", 32'(err8), 0);
    check("s3_cov", 32'(cov8), 32'h7F);
    check("s3_pass", 32'(pass8), 0);
    check("s3_done", 32'(done8), 1);

    // Saturation on the 20-vector instance.
    reset_and_start();
    run_vecs(2, 20);
    check("s4_err_sat", 32'(err20), 15);
    check("s4_vec", 32'(vec20), 20);
    check("s4_fev", 32'(fev20), 0);
    check("s4_done", 32'(done20), 1);
    check("s4_err8", 32'(err8), 8);

    // Reset mid-run.
    reset_and_start();
    run_vecs(0, 4);
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    idle();
    check("s5_busy", 32'(busy8), 0);
    check("s5_vec", 32'(vec8), 0);
    check("s5_cov", 32'(cov8), 0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
    idle();
    check("s5_vec_after", 32'(vec8), 0);

    // Hold in DONE, then restart with sample_en high.
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    run_vecs(0, 8);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    idle();
    check("s6_vec_hold", 32'(vec8), 8);
    check("s6_err_hold", 32'(err8), 0);
    check("s6_pass_hold", 32'(pass8), 1);
    step(1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
    idle();
    check("s6_busy", 32'(busy8), 1);
    check("s6_done", 32'(done8), 0);
    check("s6_pass", 32'(pass8), 0);
    check("s6_vec", 32'(vec8), 0);

    // Randomized traffic against the model.
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      logic [2:0] v;
      logic [1:0] g;
      v = 3'($urandom_range(0, 7));
      g = golden(v);
      if ($urandom_range(0, 5) == 0) g[1] = ~g[1];
      if ($urandom_range(0, 5) == 0) g[0] = ~g[0];
      step(logic'($urandom_range(0, 63) == 0), logic'($urandom_range(0, 9) == 0),
           logic'($urandom_range(0, 1)), v, g[1], g[0]);
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
